// File: rtl/cmd_pkg.sv
// Shared definitions for the byte-serial ALU command path: opcode bytes,
// request opcode encoding, issuer FSM states and the request record.
package cmd_pkg;

  localparam logic [7:0] OP_ADD = 8'h0A;
  localparam logic [7:0] OP_SUB = 8'h0B;
  localparam logic [7:0] OP_AND = 8'h0C;
  localparam logic [7:0] OP_OR  = 8'h0D;

  typedef enum logic [1:0] {
    REQ_ADD = 2'd0,
    REQ_SUB = 2'd1,
    REQ_AND = 2'd2,
    REQ_OR  = 2'd3
  } req_op_e;

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    SEND_A,
    SEND_B,
    WAIT_RES
  } state_e;

  typedef struct packed {
    req_op_e    op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_req_t;

  function automatic logic [7:0] op_byte(req_op_e op);
    case (op)
      REQ_ADD: return OP_ADD;
      REQ_SUB: return OP_SUB;
      REQ_AND: return OP_AND;
      default: return OP_OR;
    endcase
  endfunction

  // Result the command processor is expected to return for a request.
  function automatic logic [7:0] alu_ref(cmd_req_t r);
    case (r.op)
      REQ_ADD: return r.a + r.b;
      REQ_SUB: return r.a - r.b;
      REQ_AND: return r.a & r.b;
      default: return r.a | r.b;
    endcase
  endfunction

endpackage

// File: rtl/cmd_gen_timer.sv
// Loadable saturating down-counter with a zero flag; used for the inter-byte
// gap and for the result timeout.
module cmd_gen_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge res) begin
    if (res)              cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cmd_gen.sv
// Command issuer: serializes {cmd, A, B} as paced byte strobes, then waits for
// the result byte with a timeout. Define CMD_GEN_CHECK_EN for rsp_mismatch.
module cmd_gen
  import cmd_pkg::*;
#(
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       res,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic [7:0] dout_gen,
  output logic       en_dout_gen,
  input  logic       tx_busy,
  input  logic [7:0] din_res,
  input  logic       en_din_res,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout
`ifdef CMD_GEN_CHECK_EN
  ,output logic      rsp_mismatch
`endif
);

  state_e     state, state_nxt;
  cmd_req_t   req_q;
  logic       acc, can_send, issue, got_res, tmo_exp;
  logic       gap_zero, tmo_zero;
  logic [7:0] byte_nxt;

  // The FSM is already back in IDLE while rsp_valid is high; holding ready low
  // there makes the earliest new accept the cycle after the response.
  assign req_ready = (state == IDLE) & ~rsp_valid & ~res;
  assign acc       = req_valid & req_ready;
  assign can_send  = gap_zero & ~tx_busy;

  cmd_gen_timer #(.CNT_W(CNT_W)) u_gap (
    .clk      (clk),
    .res      (res),
    .load     (issue),
    .load_val (CNT_W'(GAP_CYC)),
    .zero     (gap_zero)
  );

  cmd_gen_timer #(.CNT_W(CNT_W)) u_tmo (
    .clk      (clk),
    .res      (res),
    .load     (issue && (state == SEND_B)),
    .load_val (CNT_W'(TIMEOUT_CYC)),
    .zero     (tmo_zero)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (acc)                state_nxt = SEND_CMD;
      SEND_CMD: if (issue)              state_nxt = SEND_A;
      SEND_A:   if (issue)              state_nxt = SEND_B;
      SEND_B:   if (issue)              state_nxt = WAIT_RES;
      WAIT_RES: if (got_res || tmo_exp) state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue    = 1'b0;
    byte_nxt = dout_gen;
    got_res  = 1'b0;
    tmo_exp  = 1'b0;
    case (state)
      SEND_CMD: begin issue = can_send; byte_nxt = op_byte(req_q.op); end
      SEND_A:   begin issue = can_send; byte_nxt = req_q.a;           end
      SEND_B:   begin issue = can_send; byte_nxt = req_q.b;           end
      WAIT_RES: begin
        got_res = en_din_res;
        tmo_exp = tmo_zero & ~en_din_res;  // a result on the expiry cycle wins
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res)      req_q <= '0;
    else if (acc) req_q <= '{op: req_op_e'(req_op), a: req_a, b: req_b};
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      dout_gen    <= '0;
      en_dout_gen <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      en_dout_gen <= issue;
      if (issue) dout_gen <= byte_nxt;
      rsp_valid <= got_res | tmo_exp;
      if (got_res) begin
        rsp_data    <= din_res;
        rsp_timeout <= 1'b0;
      end else if (tmo_exp) begin
        rsp_data    <= '0;
        rsp_timeout <= 1'b1;
      end
    end
  end

`ifdef CMD_GEN_CHECK_EN
  always_ff @(posedge clk or posedge res) begin
    if (res)          rsp_mismatch <= 1'b0;
    else if (got_res) rsp_mismatch <= (din_res != alu_ref(req_q));
    else if (tmo_exp) rsp_mismatch <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_cmd_gen.sv
// Bench for cmd_gen: directed vector table plus randomized transactions checked
// against a cycle-level pacing/response model derived from the issuer rules.
module tb_cmd_gen;

  localparam int GAP  = 2;
  localparam int TMO  = 10;
  localparam int MAXC = 20000;

  logic       clk = 1'b0;
  logic       res;
  logic       req_valid, req_ready;
  logic [1:0] req_op;
  logic [7:0] req_a, req_b;
  logic [7:0] dout_gen;
  logic       en_dout_gen;
  logic       tx_busy;
  logic [7:0] din_res;
  logic       en_din_res;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_timeout;
`ifdef CMD_GEN_CHECK_EN
  logic       rsp_mismatch;
`endif

  cmd_gen #(.GAP_CYC(GAP), .TIMEOUT_CYC(TMO), .CNT_W(8)) dut (
    .clk         (clk),
    .res         (res),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .dout_gen    (dout_gen),
    .en_dout_gen (en_dout_gen),
    .tx_busy     (tx_busy),
    .din_res     (din_res),
    .en_din_res  (en_din_res),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout)
`ifdef CMD_GEN_CHECK_EN
    ,.rsp_mismatch(rsp_mismatch)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log filled by the monitor, read by the checker through indices.
  int         s_cyc[$];
  logic [7:0] s_byte[$];
  int         r_cyc[$];
  logic [7:0] r_data[$];
  bit         r_tmo[$];
  bit         r_mm[$];
  int         acc_cyc[$];
  bit         rdy_hist[MAXC];
  bit         busy_hist[MAXC];

  always @(negedge clk) begin
    if (cyc < MAXC) rdy_hist[cyc] <= req_ready;
    if (!res) begin
      if (en_dout_gen) begin s_cyc.push_back(cyc); s_byte.push_back(dout_gen); end
      if (rsp_valid) begin
        r_cyc.push_back(cyc); r_data.push_back(rsp_data); r_tmo.push_back(rsp_timeout);
`ifdef CMD_GEN_CHECK_EN
        r_mm.push_back(rsp_mismatch);
`else
        r_mm.push_back(1'b0);
`endif
      end
      if (req_valid && req_ready) acc_cyc.push_back(cyc);
    end
  end

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Stimulus state applied by tick() just after each rising edge.
  bit         req_pend = 1'b0, rand_busy = 1'b0;
  logic [1:0] p_op;
  logic [7:0] p_a, p_b, drv_res_val;
  int         busy_from = -1, busy_to = -2, drv_res_cyc = -1, stray_cyc = -1;
  int         last_issue = -100;

  task automatic tick();
    @(posedge clk); #1;
    req_valid = req_pend;
    if (req_pend) begin req_op = p_op; req_a = p_a; req_b = p_b; end
    else begin req_op = 2'($urandom); req_a = 8'($urandom); req_b = 8'($urandom); end
    tx_busy = rand_busy ? ($urandom_range(0, 2) == 0) : (cyc >= busy_from && cyc <= busy_to);
    if (cyc < MAXC) busy_hist[cyc] = tx_busy;
    en_din_res = (cyc == drv_res_cyc) || (cyc == stray_cyc);
    din_res    = (cyc == drv_res_cyc) ? drv_res_val : 8'h99;
    @(negedge clk); #1;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] a, b;
    int         busy_n;   // tx_busy high for this many cycles after accept
    int         delay;    // result strobe this many cycles after the B strobe; >TMO = none
    logic [7:0] val;
    bit         stray;    // stray en_din_res while sending A
    logic [7:0] e_cmd;
    int         e_o0;     // first strobe cycle relative to accept
    int         e_ro;     // response cycle relative to accept
    logic [7:0] e_data;
    bit         e_tmo, e_mm;
  } vec_t;

  function automatic vec_t mk(logic [1:0] op, logic [7:0] a, logic [7:0] b, int busy_n,
                              int delay, logic [7:0] val, bit stray, logic [7:0] e_cmd,
                              int e_o0, int e_ro, logic [7:0] e_data, bit e_tmo, bit e_mm);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.busy_n = busy_n; v.delay = delay; v.val = val;
    v.stray = stray; v.e_cmd = e_cmd; v.e_o0 = e_o0; v.e_ro = e_ro; v.e_data = e_data;
    v.e_tmo = e_tmo; v.e_mm = e_mm;
    return v;
  endfunction

  function automatic logic [7:0] ref_alu(logic [1:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  task automatic run_txn(input vec_t v, input bit chk_offs);
    int s0, r0, a0, acc_c, sb, rc, earliest, iss, n;
    bit ok, done;
    logic [7:0] eb[3];
    eb[0] = v.e_cmd; eb[1] = v.a; eb[2] = v.b;
    s0 = s_cyc.size(); r0 = r_cyc.size(); a0 = acc_cyc.size();
    p_op = v.op; p_a = v.a; p_b = v.b; req_pend = 1'b1;
    drv_res_cyc = -1; stray_cyc = -1; busy_from = -1; busy_to = -2;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin tick(); done = acc_cyc.size() > a0; end
    req_pend = 1'b0;
    chk("accept_wait", int'(done), 1);
    if (!done) return;
    acc_c = acc_cyc[a0];
    busy_from = acc_c + 1; busy_to = acc_c + v.busy_n;
    if (v.stray) stray_cyc = acc_c + 3;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      if (drv_res_cyc < 0 && v.delay <= TMO && s_cyc.size() >= s0 + 3) begin
        drv_res_cyc = s_cyc[s0+2] + v.delay;
        drv_res_val = v.val;
      end
      done = r_cyc.size() > r0;
    end
    chk("rsp_wait", int'(done), 1);
    repeat (3) tick();

    n = s_cyc.size() - s0;
    chk("strobe_count", n, 3);
    for (int k = 0; k < 3 && k < n; k++) begin
      sb = s_cyc[s0+k];
      chk("strobe_byte", int'(s_byte[s0+k]), int'(eb[k]));
      if (chk_offs) chk("strobe_cycle", sb - acc_c, v.e_o0 + 3 * k);
      // Issue happens the cycle before the strobe: at the first cycle that is
      // past the gap, not busy, and no earlier than the state allows.
      iss = sb - 1;
      earliest = last_issue + GAP + 1;
      if (k == 0 && acc_c + 1 > earliest) earliest = acc_c + 1;
      ok = (iss >= earliest) && (iss < MAXC) && !busy_hist[iss];
      for (int j = earliest; j < iss && j < MAXC; j++) if (j >= 0 && !busy_hist[j]) ok = 1'b0;
      chk("strobe_pacing", int'(ok), 1);
      last_issue = iss;
    end

    n = r_cyc.size() - r0;
    chk("rsp_count", n, 1);
    if (n >= 1 && s_cyc.size() >= s0 + 3) begin
      rc = r_cyc[r0];
      chk("rsp_latency", rc - s_cyc[s0+2], ((v.delay <= TMO) ? v.delay : TMO) + 1);
      if (chk_offs) chk("rsp_cycle", rc - acc_c, v.e_ro);
      chk("rsp_data", int'(r_data[r0]), int'(v.e_data));
      chk("rsp_timeout", int'(r_tmo[r0]), int'(v.e_tmo));
`ifdef CMD_GEN_CHECK_EN
      chk("rsp_mismatch", int'(r_mm[r0]), int'(v.e_mm));
`endif
      chk("ready_during_rsp", int'(rdy_hist[rc]), 0);
      chk("ready_after_rsp", int'(rdy_hist[rc+1]), 1);
    end
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    int s0, r0, a0;
    bit done;
    logic [1:0] op;
    logic [7:0] a, b, rf, val;
    int d;

    //        op    a      b    busy dly  val  stray cmd   o0 ro  data  tmo mm
    tbl[0] = mk(2'd0, 8'h12, 8'h34, 0,  3, 8'h46, 0, 8'h0A, 2, 12, 8'h46, 0, 0);
    tbl[1] = mk(2'd1, 8'h10, 8'h20, 6,  2, 8'hF0, 0, 8'h0B, 8, 17, 8'hF0, 0, 0);
    tbl[2] = mk(2'd1, 8'h10, 8'h20, 0,  1, 8'h00, 0, 8'h0B, 2, 10, 8'h00, 0, 1);
    tbl[3] = mk(2'd2, 8'hA5, 8'h3C, 0, 99, 8'h00, 0, 8'h0C, 2, 19, 8'h00, 1, 0);
    tbl[4] = mk(2'd3, 8'h0F, 8'hF0, 0, 10, 8'h55, 0, 8'h0D, 2, 19, 8'h55, 0, 1);
    tbl[5] = mk(2'd3, 8'h0F, 8'hF0, 0,  5, 8'hFF, 1, 8'h0D, 2, 14, 8'hFF, 0, 0);
    tbl[6] = mk(2'd0, 8'hFF, 8'h01, 0,  4, 8'h00, 0, 8'h0A, 2, 13, 8'h00, 0, 0);

    res = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    tx_busy = 1'b0; din_res = '0; en_din_res = 1'b0;
    tick(); tick();
    chk("reset_dout_gen", int'(dout_gen), 0);
    chk("reset_en_dout_gen", int'(en_dout_gen), 0);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_data", int'(rsp_data), 0);
    chk("reset_rsp_timeout", int'(rsp_timeout), 0);
    chk("reset_req_ready", int'(req_ready), 0);
`ifdef CMD_GEN_CHECK_EN
    chk("reset_rsp_mismatch", int'(rsp_mismatch), 0);
`endif
    res = 1'b0;
    tick();
    chk("ready_after_reset", int'(req_ready), 1);

    // Stray result strobe while idle.
    s0 = s_cyc.size(); r0 = r_cyc.size();
    stray_cyc = cyc + 2;
    repeat (6) tick();
    chk("idle_stray_rsp", r_cyc.size() - r0, 0);
    chk("idle_stray_strobe", s_cyc.size() - s0, 0);
    stray_cyc = -1;

    foreach (tbl[i]) run_txn(tbl[i], 1'b1);

    // Reset right after the A strobe: abort with no B strobe and no response.
    s0 = s_cyc.size(); r0 = r_cyc.size(); a0 = acc_cyc.size();
    p_op = 2'd0; p_a = 8'h11; p_b = 8'h22; req_pend = 1'b1;
    busy_from = -1; busy_to = -2; drv_res_cyc = -1;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin tick(); done = acc_cyc.size() > a0; end
    req_pend = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin tick(); done = s_cyc.size() >= s0 + 2; end
    chk("rst_a_strobe_seen", int'(done), 1);
    res = 1'b1;
    #1;
    chk("rst_dout_gen", int'(dout_gen), 0);
    chk("rst_en_dout_gen", int'(en_dout_gen), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    tick(); tick();
    res = 1'b0;
    last_issue = -100;
    repeat (20) tick();
    chk("rst_no_b_strobe", s_cyc.size() - s0, 2);
    chk("rst_no_rsp", r_cyc.size() - r0, 0);
    run_txn(mk(2'd3, 8'h0F, 8'hF0, 0, 2, 8'hFF, 0, 8'h0D, 2, 11, 8'hFF, 0, 0), 1'b1);

    // Randomized transactions with random busy against the pacing model.
    rand_busy = 1'b1;
    for (int t = 0; t < 40; t++) begin
      op = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
      rf = ref_alu(op, a, b);
      d = $urandom_range(1, TMO + 3);
      val = ($urandom_range(0, 1) == 1) ? rf : (rf ^ 8'($urandom_range(1, 255)));
      if (d <= TMO)
        rv = mk(op, a, b, 0, d, val, ($urandom_range(0, 3) == 0), 8'h0A + 8'(op),
                0, 0, val, 1'b0, (val != rf));
      else
        rv = mk(op, a, b, 0, d, val, ($urandom_range(0, 3) == 0), 8'h0A + 8'(op),
                0, 0, 8'h00, 1'b1, 1'b0);
      run_txn(rv, 1'b0);
    end
    rand_busy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
